// File: rtl/wb_pkg.sv
// Shared types and constants for the posted write-back buffer between the victim cache and pmem.
// Optional read forwarding from buffered lines is selected with the WB_READ_FORWARD_EN macro.
package wb_pkg;

    localparam int unsigned LINE_OFFSET_W = 5;
    localparam int unsigned WB_ADDR_W     = 32;
    localparam int unsigned WB_LINE_W     = 256;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RESP
    } wb_state_e;

    typedef struct packed {
        logic                                 valid;
        logic [WB_ADDR_W-LINE_OFFSET_W-1:0]   tag;
        logic [WB_LINE_W-1:0]                 data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_array.sv
// Circular line store for the write buffer: tag match, push at tail, pop at head, in-place overwrite.
// WB_READ_FORWARD_EN adds a read port returning the matching entry's data.
module wb_entry_array #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 27,
    parameter int unsigned LINE_W = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TAG_W-1:0]             lookup_tag,
    output logic                         hit,
`ifdef WB_READ_FORWARD_EN
    output logic [LINE_W-1:0]            hit_data,
`endif
    input  logic                         push,
    input  logic                         overwrite,
    input  logic [LINE_W-1:0]            wdata,
    input  logic                         pop,
    output logic [TAG_W-1:0]             head_tag,
    output logic [LINE_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tags [DEPTH];
    logic [LINE_W-1:0] data [DEPTH];
    logic [IDX_W-1:0]  head, tail, hit_idx;
    logic [DEPTH-1:0]  match_vec;

    // Coalescing keeps at most one entry per tag, so the one-hot encode below never sees two bits set.
    always_comb begin
        match_vec = '0;
        hit_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid[i] && (tags[i] == lookup_tag);
            if (match_vec[i]) hit_idx = IDX_W'(i);
        end
    end

    assign hit       = |match_vec;
    assign head_tag  = tags[head];
    assign head_data = data[head];
`ifdef WB_READ_FORWARD_EN
    assign hit_data  = data[hit_idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tags[tail]  <= lookup_tag;
                data[tail]  <= wdata;
                tail        <= tail + 1'b1;
            end
            if (overwrite) data[hit_idx] <= wdata;
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/pmem_write_buffer.sv
// Posted write-back buffer: acknowledges evicted lines at once and drains them to pmem in FIFO order.
// WB_READ_FORWARD_EN: a read hitting a buffered line is answered from the buffer; otherwise it drains first.
module pmem_write_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] vc_pmem_address,
    input  logic              vc_pmem_read,
    input  logic              vc_pmem_write,
    input  logic [LINE_W-1:0] vc_pmem_wdata,
    output logic [LINE_W-1:0] vc_pmem_rdata,
    output logic              vc_pmem_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              wb_empty
);

    localparam int unsigned TAG_W = ADDR_W - LINE_OFFSET_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_state_e         state, state_next;
    logic              hit, full, push, overwrite, pop;
    logic [TAG_W-1:0]  head_tag;
    logic [LINE_W-1:0] head_data;
    logic [CNT_W-1:0]  count;
`ifdef WB_READ_FORWARD_EN
    logic              fwd_load;
    logic [LINE_W-1:0] hit_data;
`endif

    assign full     = (count == CNT_W'(DEPTH));
    assign wb_empty = (count == '0);

    wb_entry_array #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_entries (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (vc_pmem_address[ADDR_W-1:LINE_OFFSET_W]),
        .hit        (hit),
`ifdef WB_READ_FORWARD_EN
        .hit_data   (hit_data),
`endif
        .push       (push),
        .overwrite  (overwrite),
        .wdata      (vc_pmem_wdata),
        .pop        (pop),
        .head_tag   (head_tag),
        .head_data  (head_data),
        .count      (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A full-buffer write or (without forwarding) a matching read leaves IDLE for DRAIN and is
    // re-evaluated on return, since upstream holds its request until vc_pmem_resp.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (vc_pmem_write) begin
                    state_next = (hit || !full) ? RESP : DRAIN;
                end else if (vc_pmem_read) begin
`ifdef WB_READ_FORWARD_EN
                    state_next = hit ? RESP : READ;
`else
                    state_next = hit ? DRAIN : READ;
`endif
                end else if (count != '0) begin
                    state_next = DRAIN;
                end
            end
            READ:    if (pmem_resp) state_next = RESP;
            DRAIN:   if (pmem_resp) state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push         = 1'b0;
        overwrite    = 1'b0;
        pop          = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        vc_pmem_resp = 1'b0;
`ifdef WB_READ_FORWARD_EN
        fwd_load     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                push      = vc_pmem_write && !hit && !full;
                overwrite = vc_pmem_write && hit;
`ifdef WB_READ_FORWARD_EN
                fwd_load  = vc_pmem_read && !vc_pmem_write && hit;
`endif
            end
            READ: begin
                pmem_read    = 1'b1;
                pmem_address = vc_pmem_address;
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {head_tag, {LINE_OFFSET_W{1'b0}}};
                pmem_wdata   = head_data;
                pop          = pmem_resp;
            end
            RESP:    vc_pmem_resp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vc_pmem_rdata <= '0;
        end else if (state == READ && pmem_resp) begin
            vc_pmem_rdata <= pmem_rdata;
`ifdef WB_READ_FORWARD_EN
        end else if (fwd_load) begin
            vc_pmem_rdata <= hit_data;
`endif
        end
    end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer with a latency-programmable pmem responder and transaction log.
// Expectations for matching reads follow WB_READ_FORWARD_EN when the bench is built with it.
module tb_pmem_write_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  vc_pmem_address;
    logic         vc_pmem_read;
    logic         vc_pmem_write;
    logic [255:0] vc_pmem_wdata;
    logic [255:0] vc_pmem_rdata;
    logic         vc_pmem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         wb_empty;

    pmem_write_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .LINE_W (256)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vc_pmem_address (vc_pmem_address),
        .vc_pmem_read    (vc_pmem_read),
        .vc_pmem_write   (vc_pmem_write),
        .vc_pmem_wdata   (vc_pmem_wdata),
        .vc_pmem_rdata   (vc_pmem_rdata),
        .vc_pmem_resp    (vc_pmem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .wb_empty        (wb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } rec_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           exp_cyc;
        bit           chk_rd;
        logic [255:0] exp_rdata;
    } vec_t;

    int           total = 0;
    int           bad   = 0;
    int           lat   = 2;
    int           wait_cnt;
    rec_t         log_q[$];
    logic [255:0] mem [logic [31:0]];

    function automatic logic [255:0] line(input logic [31:0] n);
        return {8{32'hA000_0000 + n}};
    endfunction

    function automatic logic [255:0] mem_val(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_log(input int idx, input bit wr, input logic [31:0] a, input logic [255:0] d);
        if (idx < log_q.size()) begin
            chk($sformatf("log%0d_wr", idx), log_q[idx].wr, wr);
            chk($sformatf("log%0d_addr", idx), log_q[idx].addr, a);
            chk($sformatf("log%0d_data", idx), log_q[idx].data, d);
        end else begin
            chk($sformatf("log%0d_missing", idx), log_q.size(), idx + 1);
        end
    endtask

    // Drives one upstream request in an IDLE cycle, holds it to vc_pmem_resp, drops it in the RESP cycle.
    // cyc counts the request cycle plus every cycle up to and including the response.
    task automatic req(input bit wr, input logic [31:0] a, input logic [255:0] d,
                       output int cyc, output logic [255:0] rd);
        bit done = 0;
        @(posedge clk);
        @(negedge clk);
        vc_pmem_read    = !wr;
        vc_pmem_write   = wr;
        vc_pmem_address = a;
        vc_pmem_wdata   = d;
        cyc = 1;
        rd  = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (vc_pmem_resp) begin
                rd   = vc_pmem_rdata;
                done = 1;
            end
        end
        if (!done) chk("resp_timeout", vc_pmem_resp, 1);
        vc_pmem_read  = 1'b0;
        vc_pmem_write = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 400 && log_q.size() < n; i++) @(negedge clk);
        if (log_q.size() < n) chk("log_timeout", log_q.size(), n);
    endtask

    // pmem model: answers after lat extra cycles, stores writes, returns stored or default lines on reads.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            rec_t r;
            @(negedge clk);
            if (rst || pmem_resp) begin
                pmem_resp = 1'b0;
                wait_cnt  = 0;
            end else if (pmem_read || pmem_write) begin
                chk("pmem_rd_wr_excl", pmem_read & pmem_write, 0);
                if (wait_cnt >= lat) begin
                    r.wr   = pmem_write;
                    r.addr = pmem_address;
                    if (pmem_write) begin
                        r.data = pmem_wdata;
                        mem[pmem_address] = pmem_wdata;
                    end else begin
                        r.data = mem.exists(pmem_address) ? mem[pmem_address] : mem_val(pmem_address);
                        pmem_rdata = r.data;
                    end
                    log_q.push_back(r);
                    pmem_resp = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vec_t         tbl[8];
        int           cyc;
        int           base;
        logic [255:0] rd;

        // Chained requests leave no idle IDLE cycle, so nothing drains except the full-buffer stall.
        // With lat=5 a pmem access lasts 6 cycles: read miss 1+6+1=8, full write 1+6+1+1=9.
        tbl[0] = '{1, 32'h200, line(1), 2, 0, '0};
        tbl[1] = '{1, 32'h200, line(2), 2, 0, '0};
        tbl[2] = '{1, 32'h240, line(3), 2, 0, '0};
        tbl[3] = '{0, 32'h700, '0,      8, 1, mem_val(32'h700)};
        tbl[4] = '{1, 32'h280, line(4), 2, 0, '0};
        tbl[5] = '{1, 32'h2C0, line(5), 2, 0, '0};
        tbl[6] = '{1, 32'h2C0, line(7), 2, 0, '0};
        tbl[7] = '{1, 32'h300, line(6), 9, 0, '0};

        rst             = 1'b1;
        vc_pmem_read    = 1'b0;
        vc_pmem_write   = 1'b0;
        vc_pmem_address = '0;
        vc_pmem_wdata   = '0;
        #1;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk("rst_vc_resp", vc_pmem_resp, 0);
        chk("rst_vc_rdata", vc_pmem_rdata, 0);
        chk("rst_wb_empty", wb_empty, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single write accepted, then drained on its own.
        req(1, 32'h100, line(32'h10), cyc, rd);
        chk("t1_cyc", cyc, 2);
        chk("t1_not_empty", wb_empty, 0);
        wait_log(1);
        chk_log(0, 1, 32'h100, line(32'h10));
        @(posedge clk);
        #1;
        chk("t1_empty", wb_empty, 1);
        chk("t1_write_low", pmem_write, 0);

        // Coalescing, read miss before drain, overwrite while full, full-buffer stall.
        lat  = 5;
        base = log_q.size();
        for (int i = 0; i < 8; i++) begin
            req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, cyc, rd);
            chk($sformatf("tbl%0d_cyc", i), cyc, tbl[i].exp_cyc);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        end
        chk("t3_one_drain", log_q.size(), base + 2);
        wait_log(base + 6);
        chk_log(base + 0, 0, 32'h700, mem_val(32'h700));
        chk_log(base + 1, 1, 32'h200, line(2));
        chk_log(base + 2, 1, 32'h240, line(3));
        chk_log(base + 3, 1, 32'h280, line(4));
        chk_log(base + 4, 1, 32'h2C0, line(7));
        chk_log(base + 5, 1, 32'h300, line(6));
        @(posedge clk);
        #1;
        chk("t3_empty", wb_empty, 1);

        // Read of a buffered line.
        lat  = 1;
        base = log_q.size();
        req(1, 32'h300, line(3), cyc, rd);
        chk("t4_wr_cyc", cyc, 2);
        req(0, 32'h300, '0, cyc, rd);
        chk("t4_rdata", rd, line(3));
`ifdef WB_READ_FORWARD_EN
        chk("t4_fwd_cyc", cyc, 2);
        chk("t4_no_pmem", log_q.size(), base);
        wait_log(base + 1);
        chk_log(base, 1, 32'h300, line(3));
`else
        // Drain (2 cycles), one IDLE, read (2 cycles): 1+2+1+2+1 = 7.
        chk("t4_nofwd_cyc", cyc, 7);
        chk_log(base + 0, 1, 32'h300, line(3));
        chk_log(base + 1, 0, 32'h300, line(3));
`endif
        @(posedge clk);
        #1;
        chk("t4_empty", wb_empty, 1);

        // Reset during a drain drops the line; the next write works normally.
        lat  = 20;
        base = log_q.size();
        req(1, 32'h400, line(8), cyc, rd);
        chk("t6_wr_cyc", cyc, 2);
        for (int i = 0; i < 20 && !pmem_write; i++) @(negedge clk);
        chk("t6_draining", pmem_write, 1);
        rst = 1'b1;
        #1;
        chk("t6_write_drop", pmem_write, 0);
        chk("t6_empty", wb_empty, 1);
        chk("t6_resp", vc_pmem_resp, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 0;
        req(1, 32'h440, line(9), cyc, rd);
        chk("t6_post_cyc", cyc, 2);
        wait_log(base + 1);
        chk_log(base, 1, 32'h440, line(9));
        @(posedge clk);
        #1;
        chk("t6_post_empty", wb_empty, 1);
        chk("t6_log_size", log_q.size(), base + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
